// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: PC, fetch handshake with timeout/retry, held instruction
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        Branch,
  input  logic        Beq,
  input  logic        Jump,
  input  logic        Zero,
  input  logic        Gtz,
  input  logic [31:0] imm_ext,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  // RETRY doubles as the reset state: it is idle with imem_req low,
  // so the first edge after reset release lands in FETCH.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    RETRY = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   next_pc;
  logic [31:0]   br_target;
  logic          br_taken;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign br_target = pc_plus4 + (imm_ext << 2);
  assign br_taken  = Branch && ((Beq && Zero) || (!Beq && Gtz));

  // Next PC: jump outranks branch since J also raises Branch in the decoder
  always_comb begin
    next_pc = pc_plus4;
    if (Jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (br_taken) begin
      next_pc = br_target;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RETRY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_err   = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_nxt = HOLD;
        end else if (wait_cnt == CNT_LAST) begin
          fetch_err = 1'b1;
          state_nxt = RETRY;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (!stall) begin
          state_nxt = FETCH;
        end
      end
      RETRY: begin
        state_nxt = FETCH;
      end
      default: begin
        state_nxt = RETRY;
      end
    endcase
  end

  // PC, instruction register and wait counter; the counter is zeroed on every path into FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC & ~32'h3;
      instr    <= 32'h0;
      wait_cnt <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr    <= imem_rdata;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_LAST) begin
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HOLD: begin
          wait_cnt <= '0;
          if (!stall) begin
            pc <= next_pc & ~32'h3;
          end
        end
        default: begin
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        Branch;
  logic        Beq;
  logic        Jump;
  logic        Zero;
  logic        Gtz;
  logic [31:0] imm_ext;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .Branch(Branch), .Beq(Beq), .Jump(Jump),
    .Zero(Zero), .Gtz(Gtz), .imm_ext(imm_ext),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl(input logic j, input logic b, input logic q, input logic z,
                      input logic g, input logic [31:0] imm);
    Jump = j; Branch = b; Beq = q; Zero = z; Gtz = g; imm_ext = imm;
  endtask

  // Expect FETCH at addr, ack word with 1-cycle latency, expect it held in HOLD
  task automatic fetch_word(input string tag, input logic [31:0] addr, input logic [31:0] word);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    chk({tag, "_addr"}, imem_addr, addr);
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_instr"}, instr, word);
    chk({tag, "_pc"}, pc, addr);
  endtask

  // Release the held instruction with the current control inputs
  task automatic advance(input string tag);
    stall = 1'b0;
    tick();
    chk({tag, "_vdrop"}, {31'd0, instr_valid}, 32'd0);
    ctrl(0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    ctrl(0, 0, 0, 0, 0, 32'h0);
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    chk("rst_instr", instr, 32'h0);
    chk("rst_opcode", {26'd0, opcode}, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Sequential fetch 0,4,8,12
    fetch_word("seq0", 32'h0, 32'h0000_0001); advance("seq0");
    fetch_word("seq1", 32'h4, 32'h0000_0002); advance("seq1");
    fetch_word("seq2", 32'h8, 32'h0000_0003); advance("seq2");
    fetch_word("seq3", 32'hC, {6'h02, 26'h10});
    chk("seq3_opcode", {26'd0, opcode}, 32'h2);
    // Jump with Branch also high -> 0x40
    ctrl(1, 1, 0, 0, 0, 32'h0); advance("j40");
    fetch_word("at40", 32'h40, 32'h1000_0000);
    // BEQ taken, offset -2 words -> 0x3C
    ctrl(0, 1, 1, 1, 0, 32'hFFFF_FFFE); advance("beqt");
    fetch_word("at3c", 32'h3C, 32'h1000_0000);
    ctrl(0, 1, 1, 0, 0, 32'hFFFF_FFFE); advance("beqn1");
    fetch_word("at40b", 32'h40, 32'h1000_0000);
    // BEQ not taken from 0x40 -> 0x44
    ctrl(0, 1, 1, 0, 0, 32'hFFFF_FFFE); advance("beqn2");
    fetch_word("at44", 32'h44, 32'h1C00_0000);
    // BGTZ taken: 0x48 + 0x0FFFFFB8 -> 0x1000_0000
    ctrl(0, 1, 0, 0, 1, 32'h03FF_FFEE); advance("bgtz");
    fetch_word("at1000", 32'h1000_0000, {6'h02, 26'h100});
    chk("j_opcode", {26'd0, opcode}, 32'h2);
    ctrl(1, 1, 0, 1, 1, 32'h0000_0005); advance("jhi");
    fetch_word("at1000400", 32'h1000_0400, 32'hA5A5_0000);

    // Stall 5 cycles; an ack in HOLD must not disturb instr
    stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_pc", pc, 32'h1000_0400);
      chk("stall_instr", instr, 32'hA5A5_0000);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    imem_ack = 1'b0;
    // Branch to 0xFFFF_FFFC, then wrap to 0
    ctrl(0, 1, 1, 1, 0, 32'h3BFF_FEFE); advance("tofffc");
    fetch_word("atfffc", 32'hFFFF_FFFC, 32'h0);
    chk("wrap_pc4", pc_plus4, 32'h0);
    advance("wrap");

    // Timeout at cycle 16 of FETCH
    for (int i = 1; i <= 15; i++) begin
      chk("to_noerr", {31'd0, fetch_err}, 32'd0);
      chk("to_req", {31'd0, imem_req}, 32'd1);
      tick();
    end
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    tick();
    chk("retry_req", {31'd0, imem_req}, 32'd0);
    chk("retry_err", {31'd0, fetch_err}, 32'd0);
    tick();
    chk("retry_addr", imem_addr, 32'h0);
    tick(); tick(); tick();
    chk("late_noerr", {31'd0, fetch_err}, 32'd0);
    fetch_word("late", 32'h0, 32'h0BAD_F00D);
    advance("late");

    // Asynchronous reset mid-FETCH at 0x4
    tick(); tick();
    chk("prerst_addr", imem_addr, 32'h4);
    imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    chk("rel_instr", instr, 32'h0);
    chk("rel_valid", {31'd0, instr_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
